// File: rtl/fir_pkg.sv
// Shared definitions for the symmetric FIR filter: FSM state encoding,
// default widths and the rounding-constant helper.
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_ROUND = 2'd2
   } fir_state_e;

   localparam int DEF_DATA_W = 18;
   localparam int DEF_COEF_W = 18;
   localparam int DEF_FRAC_W = 12;

   // Half an LSB of the output scale, added before the arithmetic shift.
   function automatic int rnd_half(input int frac_w);
      return (frac_w > 0) ? (1 << (frac_w - 1)) : 0;
   endfunction

endpackage

// File: rtl/fir_preadd_mac.sv
// Pre-add / multiply / accumulate datapath: acc += (a + b) * c,
// with a synchronous clear that takes priority over enable.
module fir_preadd_mac
   import fir_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int ACC_W  = DEF_DATA_W + DEF_COEF_W + 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic signed [COEF_W-1:0] c,
   output logic signed [ACC_W-1:0]  acc
);

   localparam int PROD_W = DATA_W + 1 + COEF_W;

   logic signed [DATA_W:0]   sum;
   logic signed [PROD_W-1:0] prod;

   assign sum  = (DATA_W+1)'(a) + (DATA_W+1)'(b);
   assign prod = PROD_W'(sum) * PROD_W'(c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/sym_fir_filter.sv
// Linear-phase FIR with a shared pre-add MAC, runtime coefficient RAM and
// valid/ready input. Define FIR_SATURATE_EN to clamp the output instead of wrapping.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   ST_IDLE  | in_ready=1, waiting for a sample; coef writes land
//   ST_MAC   | one pre-add/multiply/accumulate per cycle, HALF cycles
//   ST_ROUND | round/limit accumulator, pulse out_valid next cycle
module sym_fir_filter
   import fir_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int COEF_W   = DEF_COEF_W,
   parameter int FRAC_W   = DEF_FRAC_W,
   parameter int NUM_TAPS = 12,
   parameter int ACC_W    = DATA_W + COEF_W + 1 + $clog2(NUM_TAPS/2)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic signed [DATA_W-1:0]          in_sample,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic signed [DATA_W-1:0]          out_sample,
   output logic                              out_valid,
   input  logic                              coef_we,
   input  logic [$clog2(NUM_TAPS/2)-1:0]     coef_addr,
   input  logic signed [COEF_W-1:0]          coef_wdata
);

   localparam int HALF   = NUM_TAPS / 2;
   localparam int ADDR_W = $clog2(HALF);
   localparam int TAP_W  = $clog2(NUM_TAPS);
   localparam int RND_K  = rnd_half(FRAC_W);

   fir_state_e               state_q, state_d;
   logic signed [DATA_W-1:0] x_q [NUM_TAPS];
   logic signed [COEF_W-1:0] c_q [HALF];
   logic [ADDR_W-1:0]        idx_q;
   logic [TAP_W-1:0]         tap_a, tap_b;
   logic                     accept, mac_en, last_mac;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W:0]    rsum, rshift;
   logic [DATA_W-1:0]        rnd_out;

   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid & in_ready;
   assign mac_en   = (state_q == ST_MAC);
   assign last_mac = (idx_q == ADDR_W'(HALF - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept)   state_d = ST_MAC;
         ST_MAC:   if (last_mac) state_d = ST_ROUND;
         ST_ROUND: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            idx_q <= '0;
         end else if (mac_en && !last_mac) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TAPS; i++) x_q[i] <= '0;
      end else if (accept) begin
         x_q[0] <= in_sample;
         for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
      end
   end

   // Writes only land while idle so a running MAC sequence never sees a torn set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HALF; i++) c_q[i] <= '0;
      end else if (coef_we && in_ready && (int'(coef_addr) < HALF)) begin
         c_q[coef_addr] <= coef_wdata;
      end
   end

   assign tap_a = TAP_W'(idx_q);
   assign tap_b = TAP_W'(NUM_TAPS - 1) - tap_a;

   fir_preadd_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .en     (mac_en),
      .a      (x_q[tap_a]),
      .b      (x_q[tap_b]),
      .c      (c_q[idx_q]),
      .acc    (acc)
   );

   // One guard bit keeps the rounding add from overflowing the accumulator.
   assign rsum   = {acc[ACC_W-1], acc} + (ACC_W+1)'(RND_K);
   assign rshift = rsum >>> FRAC_W;

`ifdef FIR_SATURATE_EN
   always_comb begin
      rnd_out = rshift[DATA_W-1:0];
      if (rshift[ACC_W:DATA_W-1] != {(ACC_W-DATA_W+2){rshift[ACC_W]}}) begin
         rnd_out = rshift[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end
`else
   logic unused_hi;
   assign rnd_out   = rshift[DATA_W-1:0];
   assign unused_hi = ^rshift[ACC_W:DATA_W];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sample <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= (state_q == ST_ROUND);
         if (state_q == ST_ROUND) out_sample <= rnd_out;
      end
   end

endmodule

// File: tb/tb_sym_fir_filter.sv
// Scoreboard bench for sym_fir_filter: a convolution model predicts each
// output at accept time; a forked monitor checks value and latency.
module tb_sym_fir_filter;

   localparam int TAPS = 12;
   localparam int HALF = 6;
   localparam int LAT  = 8;

   logic               clk;
   logic               rst_n;
   logic signed [17:0] in_sample;
   logic               in_valid;
   logic               in_ready;
   logic [17:0]        out_sample;
   logic               out_valid;
   logic               coef_we;
   logic [2:0]         coef_addr;
   logic signed [17:0] coef_wdata;

   sym_fir_filter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_sample  (in_sample),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_sample (out_sample),
      .out_valid  (out_valid),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [17:0] v;
      int          c;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic [17:0] obs[$];
   longint      hist [TAPS];
   longint      cm   [HALF];
   logic [17:0] imp_tab [TAPS];
   int          cyc;
   int          total;
   int          bad;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Direct convolution with the full symmetric impulse response.
   function automatic logic [17:0] model_out();
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < TAPS; k++)
         acc += hist[k] * cm[(k < HALF) ? k : (TAPS - 1 - k)];
      r = (acc + 2048) >>> 12;
`ifdef FIR_SATURATE_EN
      if (r > 131071)  r = 131071;
      if (r < -131072) r = -131072;
`endif
      return 18'(r);
   endfunction

   task automatic monitor();
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            q.delete();
            for (int k = 0; k < TAPS; k++) hist[k] = 0;
            for (int k = 0; k < HALF; k++) cm[k] = 0;
         end else begin
            if (out_valid) begin
               obs.push_back(out_sample);
               if (q.size() == 0) begin
                  check("spurious_out_valid", 64'(out_valid), 64'd0);
               end else begin
                  e = q.pop_front();
                  check("out_sample", 64'(out_sample), 64'(e.v));
                  check("latency", 64'(cyc - e.c), 64'(LAT));
               end
            end
            if (coef_we && in_ready && coef_addr < 3'd6)
               cm[coef_addr] = longint'(coef_wdata);
            if (in_valid && in_ready) begin
               for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
               hist[0] = longint'(in_sample);
               q.push_back('{v: model_out(), c: cyc});
            end
         end
      end
   endtask

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic send(input logic [17:0] s);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      in_sample = s;
      in_valid  = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 40) begin
            check("send_timeout", 64'(in_ready), 64'd1);
            done = 1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [17:0] d);
      coef_we    = 1'b1;
      coef_addr  = a;
      coef_wdata = d;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
   endtask

   task automatic wait_outs(input int k);
      int n;
      n = 0;
      while (obs.size() < k && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (obs.size() < k) check("outputs_timeout", 64'(obs.size()), 64'(k));
   endtask

   task automatic wait_idle();
      int  n;
      bit  idle;
      n = 0;
      idle = 0;
      while (!idle && n < 40) begin
         @(negedge clk);
         if (in_ready) idle = 1;
         n++;
      end
      if (!idle) check("idle_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      total = 0;
      bad   = 0;
      cyc   = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_sample  = '0;
      coef_we    = 1'b0;
      coef_addr  = '0;
      coef_wdata = '0;
      imp_tab = '{18'h050, 18'h1D3, 18'h041, 18'h0AE, 18'h2DB, 18'h9D0,
                  18'h9D0, 18'h2DB, 18'h0AE, 18'h041, 18'h1D3, 18'h050};

      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_sample", 64'(out_sample), 64'd0);
      check("rst_out_valid",  64'(out_valid),  64'd0);
      check("rst_in_ready",   64'(in_ready),   64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Impulse, with a write to c[0] attempted during the first MAC pass.
      for (int i = 0; i < HALF; i++) write_coef(3'(i), imp_tab[i]);
      obs.delete();
      send(18'h01000);
      write_coef(3'd0, 18'h007FF);
      for (int i = 1; i < TAPS; i++) send(18'h0);
      wait_outs(TAPS);
      for (int i = 0; i < TAPS && i < obs.size(); i++)
         check($sformatf("impulse[%0d]", i), 64'(obs[i]), 64'(imp_tab[i]));

      // DC step through 0.125 coefficients.
      for (int i = 0; i < HALF; i++) write_coef(3'(i), 18'h00200);
      obs.delete();
      for (int i = 0; i < TAPS; i++) send(18'h01000);
      wait_outs(TAPS);
      if (obs.size() >= TAPS) begin
         check("dc_first", 64'(obs[0]),  64'h200);
         check("dc_mid",   64'(obs[5]),  64'hC00);
         check("dc_final", 64'(obs[11]), 64'h1800);
      end

      // Full-scale input through unity coefficients.
      for (int i = 0; i < HALF; i++) write_coef(3'(i), 18'h01000);
      obs.delete();
      for (int i = 0; i < TAPS; i++) send(18'h1FFFF);
      wait_outs(TAPS);
      if (obs.size() >= TAPS) begin
`ifdef FIR_SATURATE_EN
         check("sat_final", 64'(obs[11]), 64'h1FFFF);
`else
         check("wrap_final", 64'(obs[11]), 64'h3FFF4);
`endif
      end

      // in_valid held high: one accept every LAT cycles.
      wait_idle();
      cnt = 0;
      in_valid  = 1'b1;
      in_sample = 18'($urandom);
      for (int i = 0; i < 6 * LAT; i++) begin
         @(negedge clk);
         if (in_ready) cnt++;
         @(posedge clk);
         #1;
         in_sample = 18'($urandom);
      end
      in_valid = 1'b0;
      check("backpressure_ready_count", 64'(cnt), 64'd6);

      // Reset in the third MAC cycle aborts the result and clears coefficients.
      wait_idle();
      send(18'h01000);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt = 0;
      @(negedge clk);
      check("ready_after_reset", 64'(in_ready), 64'd1);
      for (int i = 0; i < 12; i++) begin
         if (out_valid) cnt++;
         @(negedge clk);
      end
      check("no_out_after_abort", 64'(cnt), 64'd0);
      @(posedge clk);
      #1;
      obs.delete();
      send(18'h01000);
      for (int i = 1; i < TAPS; i++) send(18'h0);
      wait_outs(TAPS);
      cnt = 0;
      for (int i = 0; i < obs.size(); i++) if (obs[i] != 18'h0) cnt++;
      check("impulse_after_reset_nonzero", 64'(cnt), 64'd0);

      // Random traffic with coefficient writes, including same-cycle and out-of-range.
      for (int i = 0; i < 600; i++) begin
         in_valid   = ($urandom_range(0, 2) != 0);
         in_sample  = 18'($urandom);
         coef_we    = ($urandom_range(0, 3) == 0);
         coef_addr  = 3'($urandom_range(0, 7));
         coef_wdata = 18'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      coef_we  = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
